// File: rtl/axi_lite_master_module.sv
// rtl/axi_lite_master_module.sv - Single-beat AXI4-Lite initiator driven by a local command/response port.
module axi_lite_master_module #(
    parameter int          C_M_DATA_WIDTH = 32,
    parameter int          C_M_ADDR_WIDTH = 5,
    parameter logic [2:0]  C_M_PROT       = 3'b000
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [C_M_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [C_M_ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                    m_awprot,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [C_M_DATA_WIDTH-1:0]     m_wdata,
    output logic [C_M_DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [C_M_ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [C_M_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                        state, state_n;
    logic                          cmd_ready_n;
    logic                          rsp_valid_n, rsp_write_n;
    logic [C_M_DATA_WIDTH-1:0]     rsp_rdata_n;
    logic [1:0]                    rsp_resp_n;
    logic [C_M_ADDR_WIDTH-1:0]     m_awaddr_n, m_araddr_n;
    logic [C_M_DATA_WIDTH-1:0]     m_wdata_n;
    logic [C_M_DATA_WIDTH/8-1:0]   m_wstrb_n;
    logic                          m_awvalid_n, m_wvalid_n, m_bready_n, m_arvalid_n, m_rready_n;

    assign m_awprot = C_M_PROT;
    assign m_arprot = C_M_PROT;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            m_awaddr  <= '0;
            m_araddr  <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_ready <= cmd_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_write <= rsp_write_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_resp  <= rsp_resp_n;
            m_awaddr  <= m_awaddr_n;
            m_araddr  <= m_araddr_n;
            m_wdata   <= m_wdata_n;
            m_wstrb   <= m_wstrb_n;
            m_awvalid <= m_awvalid_n;
            m_wvalid  <= m_wvalid_n;
            m_bready  <= m_bready_n;
            m_arvalid <= m_arvalid_n;
            m_rready  <= m_rready_n;
        end
    end

    always_comb begin
        state_n     = state;
        cmd_ready_n = cmd_ready;
        rsp_valid_n = rsp_valid;
        rsp_write_n = rsp_write;
        rsp_rdata_n = rsp_rdata;
        rsp_resp_n  = rsp_resp;
        m_awaddr_n  = m_awaddr;
        m_araddr_n  = m_araddr;
        m_wdata_n   = m_wdata;
        m_wstrb_n   = m_wstrb;
        m_awvalid_n = m_awvalid;
        m_wvalid_n  = m_wvalid;
        m_bready_n  = m_bready;
        m_arvalid_n = m_arvalid;
        m_rready_n  = m_rready;

        case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_n = 1'b0;
                    rsp_write_n = cmd_write;
                    // Misaligned addresses are rejected locally without touching the bus.
                    if (cmd_addr[1:0] != 2'b00) begin
                        rsp_resp_n  = 2'b10;
                        rsp_rdata_n = '0;
                        rsp_valid_n = 1'b1;
                        state_n     = RSP;
                    end else if (cmd_write) begin
                        m_awaddr_n  = cmd_addr;
                        m_wdata_n   = cmd_wdata;
                        m_wstrb_n   = cmd_wstrb;
                        m_awvalid_n = 1'b1;
                        m_wvalid_n  = 1'b1;
                        state_n     = WR_REQ;
                    end else begin
                        m_araddr_n  = cmd_addr;
                        m_arvalid_n = 1'b1;
                        state_n     = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (m_awvalid && m_awready) m_awvalid_n = 1'b0;
                if (m_wvalid && m_wready)   m_wvalid_n  = 1'b0;
                if (!m_awvalid_n && !m_wvalid_n) begin
                    m_bready_n = 1'b1;
                    state_n    = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid && m_bready) begin
                    rsp_resp_n  = m_bresp;
                    rsp_rdata_n = '0;
                    m_bready_n  = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RSP;
                end
            end
            RD_REQ: begin
                if (m_arvalid && m_arready) begin
                    m_arvalid_n = 1'b0;
                    m_rready_n  = 1'b1;
                    state_n     = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid && m_rready) begin
                    rsp_rdata_n = m_rdata;
                    rsp_resp_n  = m_rresp;
                    m_rready_n  = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RSP;
                end
            end
            RSP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_master_module.sv
// tb/tb_axi_lite_master_module.sv - Self-checking bench for axi_lite_master_module with a behavioural AXI-Lite slave.
module tb_axi_lite_master_module;

    logic        aclk, areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    axi_lite_master_module dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Slave configuration, set by the stimulus process only.
    int          aw_delay, w_delay, ar_delay;
    logic [1:0]  b_resp_cfg, r_resp_cfg;
    logic        r_force;
    logic [31:0] r_force_data;

    // Slave state.
    logic [31:0] regs [8];
    int          aw_wait, w_wait, ar_wait;
    logic        aw_got, w_got;
    logic [4:0]  aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;

    assign m_awready = m_awvalid && (aw_wait >= aw_delay);
    assign m_wready  = m_wvalid  && (w_wait  >= w_delay);
    assign m_arready = m_arvalid && (ar_wait >= ar_delay);

    always @(posedge aclk or posedge areset) begin : slave
        logic        have_a, have_w;
        logic [4:0]  a_now;
        logic [31:0] d_now;
        logic [3:0]  s_now;
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_wvalid  && !m_wready)  ? w_wait + 1  : 0;
            ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
            have_a = aw_got || (m_awvalid && m_awready);
            have_w = w_got  || (m_wvalid && m_wready);
            a_now  = (m_awvalid && m_awready) ? m_awaddr : aw_a;
            d_now  = (m_wvalid && m_wready) ? m_wdata : w_d;
            s_now  = (m_wvalid && m_wready) ? m_wstrb : w_s;
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
            if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
            if (have_a && have_w && !m_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (s_now[b]) regs[a_now[4:2]][8*b +: 8] <= d_now[8*b +: 8];
                m_bvalid <= 1'b1;
                m_bresp  <= b_resp_cfg;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= r_force ? r_force_data : regs[m_araddr[4:2]];
                m_rresp  <= r_resp_cfg;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // Free-running channel activity counters, sampled mid-cycle.
    int aw_cyc, w_cyc, bus_cyc, bready_early;
    initial begin aw_cyc = 0; w_cyc = 0; bus_cyc = 0; bready_early = 0; end
    always @(negedge aclk) begin
        if (m_awvalid) aw_cyc++;
        if (m_wvalid) w_cyc++;
        if (m_awvalid || m_wvalid || m_arvalid) bus_cyc++;
        if (m_bready && (m_awvalid || m_wvalid)) bready_early++;
    end

    int n_cmp, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold,
                          output logic [1:0] resp, output logic [31:0] rdata, output logic rwrite,
                          output int lat, output logic stable, output logic after_ok);
        int n;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge aclk); n++; end
        if (n >= 20) check("cmd_accept_timeout", 32'd1, 32'd0);
        @(negedge aclk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(negedge aclk); lat++; end
        if (lat >= 50) check("rsp_timeout", 32'd1, 32'd0);
        resp = rsp_resp; rdata = rsp_rdata; rwrite = rsp_write;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            if (!(rsp_valid && rsp_resp == resp && rsp_rdata == rdata && rsp_write == rwrite && !cmd_ready))
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        after_ok = !rsp_valid && cmd_ready;
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_bus;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [1:0]  r_resp;
        logic [31:0] r_data;
        logic        r_wr, st, aok;
        int          lat, bus0, aw0, w0, be0;

        n_cmp = 0; n_fail = 0;
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_force = 1'b0; r_force_data = '0;

        vecs[0] = '{1'b1, 5'h04, 32'h0000_0100, 4'hF, 2'b00, 32'h0000_0000, 1'b1};
        vecs[1] = '{1'b1, 5'h08, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 5'h08, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 5'h08, 32'h0000_0000, 4'h0, 2'b00, 32'h00BB_00DD, 1'b1};
        vecs[4] = '{1'b0, 5'h04, 32'h0000_0000, 4'h0, 2'b00, 32'h0000_0100, 1'b1};
        vecs[5] = '{1'b1, 5'h06, 32'h1111_1111, 4'hF, 2'b10, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, 5'h03, 32'h0000_0000, 4'h0, 2'b10, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b1, 5'h1C, 32'hDEAD_BEEF, 4'b1100, 2'b00, 32'h0000_0000, 1'b1};
        vecs[8] = '{1'b0, 5'h1C, 32'h0000_0000, 4'h0, 2'b00, 32'hDEAD_0000, 1'b1};

        #1;
        check("reset_handshake_outputs",
              {26'd0, cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready | m_rready}, 32'd0);
        check("reset_rsp_fields", {29'd0, rsp_write, rsp_resp}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_bus_payload", {m_awaddr, m_araddr, m_wstrb} | m_wdata, 32'd0);
        check("prot", {26'd0, m_awprot, m_arprot}, 32'd0);

        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            bus0 = bus_cyc;
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0,
                   r_resp, r_data, r_wr, lat, st, aok);
            check($sformatf("vec%0d_resp", i), {30'd0, r_resp}, {30'd0, vecs[i].exp_resp});
            check($sformatf("vec%0d_rdata", i), r_data, vecs[i].exp_rdata);
            check($sformatf("vec%0d_write", i), {31'd0, r_wr}, {31'd0, vecs[i].wr});
            check($sformatf("vec%0d_bus_activity", i), {31'd0, (bus_cyc != bus0)}, {31'd0, vecs[i].exp_bus});
            check($sformatf("vec%0d_back_to_idle", i), {31'd0, aok}, 32'd1);
            if (!vecs[i].exp_bus)
                check($sformatf("vec%0d_local_err_latency", i), lat, 32'd0);
        end
        check("slave_reg1", regs[1], 32'h0000_0100);

        // Delayed AW, immediate W: W drops first, B waits for both.
        aw_delay = 3;
        aw0 = aw_cyc; w0 = w_cyc; be0 = bready_early;
        do_cmd(1'b1, 5'h0C, 32'h0000_5A5A, 4'hF, 0, r_resp, r_data, r_wr, lat, st, aok);
        check("aw_slow_awvalid_cycles", aw_cyc - aw0, 32'd4);
        check("aw_slow_wvalid_cycles", w_cyc - w0, 32'd1);
        check("aw_slow_bready_early", be0 - bready_early, 32'd0);
        check("aw_slow_resp", {30'd0, r_resp}, 32'd0);
        check("aw_slow_slave_reg3", regs[3], 32'h0000_5A5A);
        aw_delay = 0;

        // Delayed W, immediate AW.
        w_delay = 2;
        aw0 = aw_cyc; w0 = w_cyc;
        do_cmd(1'b1, 5'h14, 32'h0102_0304, 4'b0011, 0, r_resp, r_data, r_wr, lat, st, aok);
        check("w_slow_awvalid_cycles", aw_cyc - aw0, 32'd1);
        check("w_slow_wvalid_cycles", w_cyc - w0, 32'd3);
        check("w_slow_slave_reg5", regs[5], 32'h0000_0304);
        w_delay = 0;

        // Non-OKAY bus responses pass through unmodified.
        b_resp_cfg = 2'b01;
        do_cmd(1'b1, 5'h10, 32'h0000_0001, 4'hF, 0, r_resp, r_data, r_wr, lat, st, aok);
        check("bresp_01_passthrough", {30'd0, r_resp}, 32'd1);
        b_resp_cfg = 2'b00;
        r_resp_cfg = 2'b11;
        do_cmd(1'b0, 5'h10, 32'h0, 4'h0, 0, r_resp, r_data, r_wr, lat, st, aok);
        check("rresp_11_passthrough", {30'd0, r_resp}, 32'd3);
        check("rresp_11_rdata", r_data, 32'h0000_0001);

        // SLVERR read with back-pressured response port.
        r_resp_cfg = 2'b10; r_force = 1'b1; r_force_data = 32'h1234_5678;
        do_cmd(1'b0, 5'h10, 32'h0, 4'h0, 5, r_resp, r_data, r_wr, lat, st, aok);
        check("slverr_resp", {30'd0, r_resp}, 32'd2);
        check("slverr_rdata", r_data, 32'h1234_5678);
        check("slverr_write", {31'd0, r_wr}, 32'd0);
        check("slverr_held_stable", {31'd0, st}, 32'd1);
        check("slverr_consumed_idle", {31'd0, aok}, 32'd1);
        r_resp_cfg = 2'b00; r_force = 1'b0;

        // Reset while a read address is outstanding.
        ar_delay = 5;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h04;
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("abort_arvalid_before", {31'd0, m_arvalid}, 32'd1);
        #2 areset = 1'b1;
        #1;
        check("abort_arvalid_now", {31'd0, m_arvalid}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        ar_delay = 0;
        @(posedge aclk);
        #1;
        check("abort_cmd_ready_first_edge", {31'd0, cmd_ready}, 32'd1);
        do_cmd(1'b0, 5'h04, 32'h0, 4'h0, 0, r_resp, r_data, r_wr, lat, st, aok);
        check("post_abort_read_rdata", r_data, 32'h0000_0000);
        check("post_abort_read_resp", {30'd0, r_resp}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
